datapath_sequencer: RTL

//   Micro-sequencer driving the register-transfer datapath (RA, RB, RZ, adder, shared bus).

---
 rtl/datapath_sequencer_if.sv | 32 +++
 rtl/datapath_sequencer.sv | 106 ++++++++++
 2 files changed

// File: rtl/datapath_sequencer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// datapath_sequencer_if : command handshake and datapath-control bundle
// Rev 1.0
// ----------------------------------------------------------------------------
interface datapath_sequencer_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic [1:0]       op;
  logic [CNT_W-1:0] count;
  logic             busy;
  logic             done;
  logic             err;
  logic             RAin;
  logic             RBin;
  logic             RZin;
  logic             RAout;
  logic             RBout;
  logic             RZout;

  modport master (
    output start, op, count,
    input  busy, done, err, RAin, RBin, RZin, RAout, RBout, RZout
  );

  modport slave (
    input  start, op, count,
    output busy, done, err, RAin, RBin, RZin, RAout, RBout, RZout
  );
endinterface
`default_nettype wire

// File: rtl/datapath_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// datapath_sequencer : Moore micro-sequencer for the RA/RB/RZ register datapath
// Rev 1.0
// ----------------------------------------------------------------------------
module datapath_sequencer #(
  parameter int CNT_W = 8
) (
  input  wire logic             clock,
  input  wire logic             clear,
  datapath_sequencer_if.slave   bus
);
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    MOVE = 3'd2,
    ADD  = 3'd3,
    WB   = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] remaining;
  logic             err_flag;

  logic busy_q, done_q, err_q;
  logic ra_in_q, rb_in_q, rz_in_q, ra_out_q, rb_out_q, rz_out_q;

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          case (bus.op)
            2'd0:    next_state = LOAD;
            2'd1:    next_state = MOVE;
            2'd2:    next_state = (bus.count != '0) ? ADD : DONE;
            default: next_state = DONE;
          endcase
        end
      end
      LOAD:    next_state = DONE;
      MOVE:    next_state = DONE;
      ADD:     next_state = WB;
      // remaining is at least one here, so remaining==1 means the last pair
      WB:      next_state = (remaining != ONE) ? ADD : DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are registered from the state being entered, so they track state exactly.
  always_ff @(posedge clock) begin
    if (clear) begin
      state     <= IDLE;
      remaining <= '0;
      err_flag  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ra_in_q   <= 1'b0;
      rb_in_q   <= 1'b0;
      rz_in_q   <= 1'b0;
      ra_out_q  <= 1'b0;
      rb_out_q  <= 1'b0;
      rz_out_q  <= 1'b0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (bus.start) begin
            remaining <= bus.count;
            err_flag  <= (bus.op == 2'd3);
          end
        end
        WB:      remaining <= remaining - ONE;
        DONE:    err_flag  <= 1'b0;
        default: ;
      endcase
      busy_q   <= (next_state != IDLE);
      done_q   <= (next_state == DONE);
      err_q    <= (next_state == DONE) &&
                  ((state == IDLE) ? (bus.op == 2'd3) : err_flag);
      ra_in_q  <= (next_state == LOAD);
      rb_in_q  <= (next_state == MOVE) || (next_state == WB);
      rz_in_q  <= (next_state == ADD);
      ra_out_q <= (next_state == MOVE);
      rb_out_q <= (next_state == ADD);
      rz_out_q <= (next_state == WB);
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.err   = err_q;
  assign bus.RAin  = ra_in_q;
  assign bus.RBin  = rb_in_q;
  assign bus.RZin  = rz_in_q;
  assign bus.RAout = ra_out_q;
  assign bus.RBout = rb_out_q;
  assign bus.RZout = rz_out_q;
endmodule
`default_nettype wire
